// File: rtl/asic_unlock_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : asic_unlock_seq_if
// Description : CPU write-side bus seen by the Plus-ASIC unlock detector.
//               master : bus decode / CPU side, drives every signal.
//               slave  : unlock detector, samples every signal.
//   plus_mode    Plus mode enable
//   cpu_addr     CPU address [15:0]
//   cpu_data_in  CPU write data [7:0]
//   cpu_wr       CPU write strobe (level)
// Revision    : 1.0 - initial release
// ============================================================================
interface asic_unlock_seq_if;
    logic        plus_mode;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_wr;

    modport master (
        output plus_mode,
        output cpu_addr,
        output cpu_data_in,
        output cpu_wr
    );

    modport slave (
        input plus_mode,
        input cpu_addr,
        input cpu_data_in,
        input cpu_wr
    );
endinterface
`default_nettype wire

// File: rtl/asic_unlock_seq.sv
`default_nettype none
// ============================================================================
// Module      : asic_unlock_seq
// Description : Plus-ASIC unlock detector. Watches CPU writes to the CRTC
//               select port (PORT_HI:xx) and matches a programmable byte
//               sequence. The final decision byte either unlocks the ASIC
//               (asic_valid=1, enabling the 4000-7FFF ASIC page) or re-locks
//               it. Includes resync on mismatch, an optional inter-byte
//               timeout and a saturating attempt counter.
//
// Ports:
//   clk_sys        in   system clock
//   reset_n        in   asynchronous active-low reset
//   bus            slv  asic_unlock_seq_if (plus_mode, cpu_addr,
//                       cpu_data_in, cpu_wr)
//   asic_valid     out  ASIC unlocked
//   unlock_pulse   out  one-cycle pulse on the unlock decision
//   lock_pulse     out  one-cycle pulse on the re-lock decision
//   seq_index      out  next expected sequence position
//   attempt_count  out  saturating count of decision bytes received
//   dbg_fail_index out  position of the last pattern mismatch
//   dbg_fail_byte  out  data of the last pattern mismatch
//
// Build option:
//   ASIC_UNLOCK_TRACE_EN  when defined, the last pattern mismatch is latched
//                         on dbg_fail_index/dbg_fail_byte; when undefined both
//                         are tied to zero and no trace registers exist.
//
// Revision    : 1.0 - initial release
// ============================================================================
module asic_unlock_seq #(
    parameter int                         SEQ_LEN     = 16,
    parameter logic [(SEQ_LEN-1)*8-1:0]   SEQ         = {8'hFF, 8'h00, 8'hFF, 8'h77,
                                                         8'hB3, 8'h51, 8'hA8, 8'hD4,
                                                         8'h62, 8'h39, 8'h9C, 8'h46,
                                                         8'h2B, 8'h15, 8'h8A},
    parameter logic [7:0]                 UNLOCK_BYTE = 8'hCD,
    parameter logic [7:0]                 PORT_HI     = 8'hBC,
    parameter int                         TIMEOUT_CYC = 0,
    parameter int                         CNT_W       = 8,
    localparam int                        IDX_W       = $clog2(SEQ_LEN)
) (
    input  wire logic               clk_sys,
    input  wire logic               reset_n,
    asic_unlock_seq_if.slave        bus,
    output logic                    asic_valid,
    output logic                    unlock_pulse,
    output logic                    lock_pulse,
    output logic [IDX_W-1:0]        seq_index,
    output logic [CNT_W-1:0]        attempt_count,
    output logic [IDX_W-1:0]        dbg_fail_index,
    output logic [7:0]              dbg_fail_byte
);

    // Position of the decision byte; every lower index is a pattern byte.
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(SEQ_LEN - 1);

    logic       r_wr_d;          // cpu_wr delayed one cycle, for edge detect
    logic       w_accept;        // one accepted port write this cycle
    logic       w_is_decision;   // current position is the decision byte
    logic       w_match;         // data equals the expected pattern byte
    logic       w_first;         // data equals pattern byte 0 (resync)
    logic       w_timeout;       // inter-byte timeout expires this cycle
    logic [7:0] w_exp [SEQ_LEN]; // pattern unpacked to one byte per position
    logic       w_unused_addr_lo;

    // ------------------------------------------------------------------------
    // Pattern unpacking: byte 0 lives in the MSBs of SEQ. The decision slot
    // gets a dummy entry so the table covers every reachable index.
    // ------------------------------------------------------------------------
    genvar k;
    generate
        for (k = 0; k < SEQ_LEN - 1; k++) begin : g_pat
            assign w_exp[k] = SEQ[(SEQ_LEN-2-k)*8 +: 8];
        end
    endgenerate
    assign w_exp[SEQ_LEN-1] = 8'h00;

    // Only the port page is decoded; the low address byte is don't-care.
    assign w_unused_addr_lo = ^bus.cpu_addr[7:0];

    // A level strobe counts once: only its first cycle is accepted.
    assign w_accept = bus.cpu_wr && !r_wr_d && bus.plus_mode &&
                      (bus.cpu_addr[15:8] == PORT_HI);

    assign w_is_decision = (seq_index == c_last_idx);
    assign w_match       = (bus.cpu_data_in == w_exp[seq_index]);
    assign w_first       = (bus.cpu_data_in == w_exp[0]);

    // ------------------------------------------------------------------------
    // Inter-byte timeout. The counter holds the number of idle cycles seen
    // since the last accepted write while a sequence is in progress; the
    // timeout fires on the TIMEOUT_CYC-th such cycle. An accepted write in
    // the same cycle suppresses it, so the write is evaluated at the current
    // index.
    // ------------------------------------------------------------------------
    generate
        if (TIMEOUT_CYC > 0) begin : g_timeout
            localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYC - 1);

            logic [TMO_W-1:0] r_tmo_cnt;

            assign w_timeout = bus.plus_mode && !w_accept &&
                               (seq_index != '0) && (r_tmo_cnt == c_tmo_last);

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    r_tmo_cnt <= '0;
                end else if (!bus.plus_mode || w_accept || w_timeout ||
                             (seq_index == '0)) begin
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Sequence state machine. seq_index is the state: 0..SEQ_LEN-2 are
    // pattern positions, SEQ_LEN-1 is the decision position. All outputs are
    // registered here.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_d        <= 1'b0;
            seq_index     <= '0;
            asic_valid    <= 1'b0;
            unlock_pulse  <= 1'b0;
            lock_pulse    <= 1'b0;
            attempt_count <= '0;
        end else begin
            r_wr_d       <= bus.cpu_wr;
            unlock_pulse <= 1'b0;
            lock_pulse   <= 1'b0;

            if (!bus.plus_mode) begin
                // Leaving Plus mode drops the unlock and any partial match;
                // the attempt history is kept.
                seq_index  <= '0;
                asic_valid <= 1'b0;
            end else if (w_accept) begin
                if (w_is_decision) begin
                    seq_index <= '0;
                    if (bus.cpu_data_in == UNLOCK_BYTE) begin
                        asic_valid   <= 1'b1;
                        unlock_pulse <= 1'b1;
                    end else begin
                        asic_valid <= 1'b0;
                        lock_pulse <= 1'b1;
                    end
                    if (attempt_count != '1) begin
                        attempt_count <= attempt_count + 1'b1;
                    end
                end else if (w_match) begin
                    seq_index <= seq_index + 1'b1;
                end else if (w_first) begin
                    // Mismatching byte may itself start a new sequence.
                    seq_index <= IDX_W'(1);
                end else begin
                    seq_index <= '0;
                end
            end else if (w_timeout) begin
                seq_index <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Mismatch trace
    // ------------------------------------------------------------------------
`ifdef ASIC_UNLOCK_TRACE_EN
    logic w_mismatch;

    assign w_mismatch = w_accept && !w_is_decision && !w_match;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dbg_fail_index <= '0;
            dbg_fail_byte  <= '0;
        end else if (w_mismatch) begin
            dbg_fail_index <= seq_index;
            dbg_fail_byte  <= bus.cpu_data_in;
        end
    end
`else
    assign dbg_fail_index = '0;
    assign dbg_fail_byte  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_asic_unlock_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_asic_unlock_seq
// Description : Self-checking bench for asic_unlock_seq. Two instances share
//               one bus: u_dut with default parameters and u_dut_t with a
//               100-cycle timeout and a 2-bit attempt counter. A behavioural
//               model of each runs alongside and is compared every cycle;
//               table vectors and hand sequences add fixed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asic_unlock_seq;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    asic_unlock_seq_if bus ();

    logic       v0, up0, lp0, v1, up1, lp1;
    logic [3:0] idx0, idx1, fi0, fi1;
    logic [7:0] att0, fb0, fb1;
    logic [1:0] att1;

    asic_unlock_seq u_dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .bus            (bus),
        .asic_valid     (v0),
        .unlock_pulse   (up0),
        .lock_pulse     (lp0),
        .seq_index      (idx0),
        .attempt_count  (att0),
        .dbg_fail_index (fi0),
        .dbg_fail_byte  (fb0)
    );

    asic_unlock_seq #(.TIMEOUT_CYC(100), .CNT_W(2)) u_dut_t (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .bus            (bus),
        .asic_valid     (v1),
        .unlock_pulse   (up1),
        .lock_pulse     (lp1),
        .seq_index      (idx1),
        .attempt_count  (att1),
        .dbg_fail_index (fi1),
        .dbg_fail_byte  (fb1)
    );

    // Default pattern, one byte per position.
    logic [7:0] pat [15] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8,
                             8'hD4, 8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15,
                             8'h8A};

    // ------------------------------------------------------------------------
    // Reference model: position, unlock flag, attempt tally and idle-cycle
    // count since the last accepted byte.
    // ------------------------------------------------------------------------
    typedef struct {
        int idx;
        bit valid;
        bit up;
        bit lp;
        int att;
        int idle;
        int fidx;
        int fbyte;
    } mdl_t;

    mdl_t m0, m1;
    bit   prev_wr;
    logic acc;

    assign acc = bus.cpu_wr && !prev_wr && bus.plus_mode &&
                 (bus.cpu_addr[15:8] == 8'hBC);

    function automatic mdl_t step(input mdl_t s, input bit a, input bit plus,
                                  input logic [7:0] d, input int tmo,
                                  input int att_max);
        mdl_t n;
        n    = s;
        n.up = 1'b0;
        n.lp = 1'b0;
        if (!plus) begin
            n.idx   = 0;
            n.valid = 1'b0;
            n.idle  = 0;
        end else if (a) begin
            n.idle = 0;
            if (s.idx == 15) begin
                n.idx   = 0;
                n.valid = (d == 8'hCD);
                n.up    = (d == 8'hCD);
                n.lp    = (d != 8'hCD);
                if (s.att < att_max) n.att = s.att + 1;
            end else if (d == pat[s.idx]) begin
                n.idx = s.idx + 1;
            end else begin
                n.idx   = (d == pat[0]) ? 1 : 0;
                n.fidx  = s.idx;
                n.fbyte = d;
            end
        end else if (tmo > 0 && s.idx != 0) begin
            n.idle = s.idle + 1;
            if (n.idle >= tmo) begin
                n.idx  = 0;
                n.idle = 0;
            end
        end else begin
            n.idle = 0;
        end
        return n;
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m0      <= '{default: 0};
            m1      <= '{default: 0};
            prev_wr <= 1'b0;
        end else begin
            m0      <= step(m0, acc, bus.plus_mode, bus.cpu_data_in, 0, 255);
            m1      <= step(m1, acc, bus.plus_mode, bus.cpu_data_in, 100, 3);
            prev_wr <= bus.cpu_wr;
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_idx0",   32'(idx0), m0.idx);
        chk("m_valid0", 32'(v0),   32'(m0.valid));
        chk("m_up0",    32'(up0),  32'(m0.up));
        chk("m_lp0",    32'(lp0),  32'(m0.lp));
        chk("m_att0",   32'(att0), m0.att);
        chk("m_idx1",   32'(idx1), m1.idx);
        chk("m_valid1", 32'(v1),   32'(m1.valid));
        chk("m_up1",    32'(up1),  32'(m1.up));
        chk("m_lp1",    32'(lp1),  32'(m1.lp));
        chk("m_att1",   32'(att1), m1.att);
`ifdef ASIC_UNLOCK_TRACE_EN
        chk("m_fidx0",  32'(fi0),  m0.fidx);
        chk("m_fbyte0", 32'(fb0),  m0.fbyte);
        chk("m_fidx1",  32'(fi1),  m1.fidx);
        chk("m_fbyte1", 32'(fb1),  m1.fbyte);
`else
        chk("m_fidx0",  32'(fi0),  0);
        chk("m_fbyte0", 32'(fb0),  0);
        chk("m_fidx1",  32'(fi1),  0);
        chk("m_fbyte1", 32'(fb1),  0);
`endif
    endtask

    task automatic tick();
        @(negedge clk_sys);
        check_model();
    endtask

    // One strobe followed by one idle cycle.
    task automatic send_byte(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr    = a;
        bus.cpu_data_in = d;
        bus.cpu_wr      = 1'b1;
        tick();
        bus.cpu_wr = 1'b0;
        tick();
    endtask

    // Full pattern, then the decision strobe; returns one cycle after it.
    task automatic full_seq(input logic [7:0] dec);
        for (int i = 0; i < 15; i++) send_byte(16'hBC00, pat[i]);
        bus.cpu_addr    = 16'hBC00;
        bus.cpu_data_in = dec;
        bus.cpu_wr      = 1'b1;
        tick();
        bus.cpu_wr = 1'b0;
    endtask

    task automatic clear_seq();
        bus.plus_mode = 1'b0;
        tick();
        bus.plus_mode = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        plus;
        int          exp_idx;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs = '{
            '{16'hBC00, 8'hFF, 1'b1, 1}, '{16'hBC00, 8'h00, 1'b1, 2},
            '{16'hBC00, 8'hFF, 1'b1, 3}, '{16'hBC00, 8'h77, 1'b1, 4},
            '{16'hBC00, 8'hFF, 1'b1, 1}, '{16'hBC00, 8'h00, 1'b1, 2},
            '{16'hBC00, 8'hFF, 1'b1, 3}, '{16'hBC00, 8'h77, 1'b1, 4},
            '{16'hBC00, 8'hB3, 1'b1, 5}, '{16'hBD00, 8'h00, 1'b1, 5},
            '{16'h3C12, 8'h51, 1'b1, 5}, '{16'hBC34, 8'h51, 1'b1, 6},
            '{16'hBC00, 8'h00, 1'b1, 0}, '{16'hBC00, 8'hFF, 1'b1, 1},
            '{16'hBC00, 8'h00, 1'b0, 0}, '{16'hBC00, 8'hFF, 1'b1, 1}
        };

        bus.plus_mode   = 1'b1;
        bus.cpu_addr    = 16'h0000;
        bus.cpu_data_in = 8'h00;
        bus.cpu_wr      = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_valid", 32'(v0),   0);
        chk("rst_idx",   32'(idx0), 0);
        chk("rst_att",   32'(att0), 0);
        chk("rst_pulse", 32'({up0, lp0, up1, lp1}), 0);
        reset_n = 1'b1;
        tick();

        // Unlock
        full_seq(8'hCD);
        chk("unl_valid", 32'(v0),   1);
        chk("unl_pulse", 32'(up0),  1);
        chk("unl_idx",   32'(idx0), 0);
        chk("unl_att",   32'(att0), 1);
        chk("unl_att_t", 32'(att1), 1);
        tick();
        chk("unl_pulse_end", 32'(up0), 0);
        chk("unl_hold",      32'(v0),  1);

        // Re-lock
        full_seq(8'hA5);
        chk("lck_valid", 32'(v0),   0);
        chk("lck_pulse", 32'(lp0),  1);
        chk("lck_up",    32'(up0),  0);
        chk("lck_att",   32'(att0), 2);
        tick();
        chk("lck_pulse_end", 32'(lp0), 0);

        // Table: resync, foreign ports, plus_mode gating
        for (int i = 0; i < 16; i++) begin
            bus.plus_mode = vecs[i].plus;
            send_byte(vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d_idx", i), 32'(idx0), vecs[i].exp_idx);
`ifdef ASIC_UNLOCK_TRACE_EN
            if (i == 4) begin
                chk("trace_idx",  32'(fi0), 4);
                chk("trace_byte", 32'(fb0), 8'hFF);
            end
`endif
        end
        bus.plus_mode = 1'b1;

        // Timeout expiry on the 100th idle cycle (u_dut_t only)
        clear_seq();
        send_byte(16'hBC00, 8'hFF);
        send_byte(16'hBC00, 8'h00);
        repeat (98) tick();
        chk("tmo_99", 32'(idx1), 2);
        tick();
        chk("tmo_100", 32'(idx1), 0);
        chk("tmo_none", 32'(idx0), 2);

        // Write landing on the timeout cycle is evaluated at index 2
        clear_seq();
        send_byte(16'hBC00, 8'hFF);
        send_byte(16'hBC00, 8'h00);
        repeat (98) tick();
        bus.cpu_data_in = 8'hFF;
        bus.cpu_wr      = 1'b1;
        tick();
        chk("tmo_race", 32'(idx1), 3);
        bus.cpu_wr = 1'b0;
        tick();

        // Held strobe accepts one byte
        clear_seq();
        bus.cpu_addr    = 16'hBC00;
        bus.cpu_data_in = 8'hFF;
        bus.cpu_wr      = 1'b1;
        repeat (10) tick();
        chk("held_idx",   32'(idx0), 1);
        chk("held_idx_t", 32'(idx1), 1);
        bus.cpu_wr = 1'b0;
        tick();

        // Attempt counter saturation on the 2-bit instance
        clear_seq();
        full_seq(8'hCD);
        tick();
        chk("sat_3", 32'(att1), 3);
        full_seq(8'hCD);
        tick();
        chk("sat_hold", 32'(att1), 3);
        chk("sat_wide", 32'(att0), 4);

        // Asynchronous reset mid-sequence
        send_byte(16'hBC00, 8'hFF);
        send_byte(16'hBC00, 8'h00);
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_idx",   32'({idx0, idx1}), 0);
        chk("arst_valid", 32'({v0, v1}),     0);
        chk("arst_att",   32'({att0, att1}), 0);
        chk("arst_pulse", 32'({up0, lp0, up1, lp1}), 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int sel;
            bus.plus_mode = ($urandom_range(0, 199) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)      bus.cpu_addr = {8'hBC, 8'($urandom)};
            else if (sel < 9) bus.cpu_addr = {8'hBD, 8'($urandom)};
            else              bus.cpu_addr = 16'($urandom);
            if ($urandom_range(0, 15) != 0)
                bus.cpu_data_in = (m0.idx < 15) ? pat[m0.idx]
                                  : ($urandom_range(0, 1) ? 8'hCD : 8'($urandom));
            else
                bus.cpu_data_in = 8'($urandom);
            bus.cpu_wr = 1'($urandom_range(0, 1));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
